shift_ex_stage: RTL

Two-stage execute-pipeline wrapper around the 16-bit barrel shifter (SLL / SRA / ROR).
- Accepts shift micro-ops from ID/EX over a valid/ready handshake and registers the operands.
- Drives the combinational shifter from those operand registers, then registers the result, destination tag and Z flag toward EX/MEM.
- Supports backpressure, pipeline flush on branch mispredict, and rejection of the illegal mode code.

---
 rtl/shift_ex_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/shift_ex_stage.sv
// Shift execute stage: operand register, barrel shifter, result register.
// Carries SLL/SRA/ROR micro-ops from ID/EX to EX/MEM over valid/ready.
module shift_barrel #(
    parameter int DW = 16,
    parameter int SW = 4
) (
    input  logic [DW-1:0] data,
    input  logic [SW-1:0] amt,
    input  logic [1:0]    mode,
    output logic [DW-1:0] result
);

    logic [DW-1:0] acc;
    logic          is_sll;
    logic          is_sra;
    logic          is_ror;
    logic          is_bad;

    assign is_sll = (mode == 2'b00);
    assign is_sra = (mode == 2'b01);
    assign is_ror = (mode == 2'b10);
    assign is_bad = (mode == 2'b11);

    // Log-depth shifter: stage k moves by 2**k when amt[k] is set.
    always_comb begin
        acc = data;
        for (int k = 0; k < SW; k++) begin
            if (amt[k]) begin
                unique case (1'b1)
                    is_sll: acc = acc << (2 ** k);
                    is_sra: acc = $signed(acc) >>> (2 ** k);
                    is_ror: acc = (acc >> (2 ** k))
                                | (acc << (DW - 2 ** k));
                    is_bad: acc = acc;
                endcase
            end
        end
    end

    assign result = acc;

endmodule

module shift_ex_stage #(
    parameter int DW   = 16,
    parameter int SW   = 4,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [SW-1:0]   in_amt,
    input  logic [1:0]      in_mode,
    input  logic [TAGW-1:0] in_tag,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [TAGW-1:0] out_tag,
    output logic            out_err,
    output logic            z_flag
);

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [SW-1:0]   amt;
        logic [1:0]      mode;
        logic [TAGW-1:0] tag;
    } op_t;

    op_t           s1;
    logic          s1_valid;
    logic          s2_can_load;
    logic          accept;
    logic          s1_move;
    logic          out_fire;
    logic [DW-1:0] shift_res;

    assign s2_can_load = ~out_valid | out_ready;
    assign in_ready    = ~s1_valid | s2_can_load;
    assign accept      = in_valid & in_ready;
    assign s1_move     = s1_valid & s2_can_load;
    assign out_fire    = out_valid & out_ready;

    shift_barrel #(
        .DW (DW),
        .SW (SW)
    ) u_shift (
        .data   (s1.data),
        .amt    (s1.amt),
        .mode   (s1.mode),
        .result (shift_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
        end else if (accept) begin
            s1.data <= in_data;
            s1.amt  <= in_amt;
            s1.mode <= in_mode;
            s1.tag  <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_can_load) begin
            out_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_tag  <= '0;
            out_err  <= 1'b0;
        end else if (s1_move) begin
            out_data <= shift_res;
            out_tag  <= s1.tag;
            out_err  <= (s1.mode == 2'b11);
        end
    end

    // A result leaving in a flush cycle is still architecturally consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_flag <= 1'b0;
        end else if (out_fire & ~out_err) begin
            z_flag <= (out_data == '0);
        end
    end

endmodule
